cellram_wbuf: RTL and testbench

- Posted-write buffer and Wishbone bridge between the CPU data bus (slave side) and the CellRAM controller (master side).
- Acks CPU writes in one cycle while the controller's multi-cycle writes drain in the background.
- Reads are ordered behind all buffered writes.
- Upstream of the CellRAM controller; all signals on the single bus clock.

---
 rtl/cellram_wbuf.sv | 201 ++++++++++++++++++++
 tb/tb_cellram_wbuf.sv | 473 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cellram_wbuf.sv
// cellram_wbuf: posted-write FIFO and Wishbone bridge placed in front of the CellRAM controller.
// Define CELLRAM_WBUF_FWD_EN to let reads be answered from full-word entries still in the FIFO.
module cellram_wbuf #(
    parameter int DEPTH_LOG2 = 2,
    parameter int ADR_WIDTH  = 32
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic [ADR_WIDTH-1:0] s_wb_adr_i,
    input  logic [31:0]          s_wb_dat_i,
    input  logic [3:0]           s_wb_sel_i,
    input  logic                 s_wb_we_i,
    input  logic                 s_wb_stb_i,
    input  logic                 s_wb_cyc_i,
    output logic [31:0]          s_wb_dat_o,
    output logic                 s_wb_ack_o,
    output logic [ADR_WIDTH-1:0] m_wb_adr_o,
    output logic [31:0]          m_wb_dat_o,
    output logic [3:0]           m_wb_sel_o,
    output logic                 m_wb_we_o,
    output logic                 m_wb_stb_o,
    output logic                 m_wb_cyc_o,
    input  logic [31:0]          m_wb_dat_i,
    input  logic                 m_wb_ack_i,
    output logic                 wbuf_empty_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, WR, RD, GAP} state_t;

    state_t                 state_q;
    logic [ADR_WIDTH-1:0]   fifoAdr_q [DEPTH];
    logic [31:0]            fifoDat_q [DEPTH];
    logic [3:0]             fifoSel_q [DEPTH];
    logic [DEPTH_LOG2-1:0]  wrPtr_q, wrPtr_d;
    logic [DEPTH_LOG2-1:0]  rdPtr_q, rdPtr_d;
    logic [DEPTH_LOG2:0]    count_q, count_d;

    logic                   sAck_q;
    logic [31:0]            sDat_q;
    logic [ADR_WIDTH-1:0]   mAdr_q;
    logic [31:0]            mDat_q;
    logic [3:0]             mSel_q;
    logic                   mWe_q, mStb_q, mCyc_q;
    logic                   empty_q;

    logic req, wrReq, rdReq, full, push, pop, rdDone, rdIssue, fwdHit, nextIdle;

    // The ack register blocks a second request in the cycle the previous one is being acked.
    assign req     = s_wb_stb_i & s_wb_cyc_i & ~sAck_q;
    assign wrReq   = req & s_wb_we_i;
    assign rdReq   = req & ~s_wb_we_i;
    assign full    = (count_q == FULL_COUNT);
    assign pop     = (state_q == WR) & m_wb_ack_i;
    assign push    = wrReq & (~full | pop);
    assign rdDone  = (state_q == RD) & m_wb_ack_i;
    assign rdIssue = (state_q == IDLE) & (count_q == '0) & rdReq & ~fwdHit;
    assign nextIdle = ((state_q == IDLE) & (count_q == '0) & ~rdIssue) | (state_q == GAP);

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (push) begin
            wrPtr_d = wrPtr_q + 1'b1;
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

`ifdef CELLRAM_WBUF_FWD_EN
    logic                  fullMatch, partMatch;
    logic [31:0]           fwdDat;
    logic [DEPTH_LOG2-1:0] idx;

    // Walk from oldest to youngest so the last full-word hit wins; any partial hit vetoes forwarding.
    always_comb begin
        fullMatch = 1'b0;
        partMatch = 1'b0;
        fwdDat    = '0;
        idx       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rdPtr_q + DEPTH_LOG2'(i);
            if (((DEPTH_LOG2 + 1)'(i) < count_q) &&
                (fifoAdr_q[idx][ADR_WIDTH-1:2] == s_wb_adr_i[ADR_WIDTH-1:2])) begin
                if (fifoSel_q[idx] == 4'b1111) begin
                    fullMatch = 1'b1;
                    fwdDat    = fifoDat_q[idx];
                end else begin
                    partMatch = 1'b1;
                end
            end
        end
    end

    assign fwdHit = rdReq & fullMatch & ~partMatch;
`else
    assign fwdHit = 1'b0;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            fifoAdr_q[wrPtr_q] <= s_wb_adr_i;
            fifoDat_q[wrPtr_q] <= s_wb_dat_i;
            fifoSel_q[wrPtr_q] <= s_wb_sel_i;
        end
    end

    // Master FSM plus every registered output; GAP keeps stb low for one cycle between accesses.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            sAck_q  <= 1'b0;
            sDat_q  <= '0;
            mAdr_q  <= '0;
            mDat_q  <= '0;
            mSel_q  <= '0;
            mWe_q   <= 1'b0;
            mStb_q  <= 1'b0;
            mCyc_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
            sAck_q  <= push | rdDone | fwdHit;
            empty_q <= (count_d == '0) & nextIdle;
            if (rdDone) begin
                sDat_q <= m_wb_dat_i;
            end
`ifdef CELLRAM_WBUF_FWD_EN
            else if (fwdHit) begin
                sDat_q <= fwdDat;
            end
`endif
            case (state_q)
                IDLE: begin
                    if (count_q != '0) begin
                        mAdr_q  <= fifoAdr_q[rdPtr_q];
                        mDat_q  <= fifoDat_q[rdPtr_q];
                        mSel_q  <= fifoSel_q[rdPtr_q];
                        mWe_q   <= 1'b1;
                        mStb_q  <= 1'b1;
                        mCyc_q  <= 1'b1;
                        state_q <= WR;
                    end else if (rdIssue) begin
                        mAdr_q  <= s_wb_adr_i;
                        mSel_q  <= s_wb_sel_i;
                        mWe_q   <= 1'b0;
                        mStb_q  <= 1'b1;
                        mCyc_q  <= 1'b1;
                        state_q <= RD;
                    end
                end
                WR: begin
                    if (m_wb_ack_i) begin
                        mWe_q   <= 1'b0;
                        mStb_q  <= 1'b0;
                        mCyc_q  <= 1'b0;
                        state_q <= GAP;
                    end
                end
                RD: begin
                    if (m_wb_ack_i) begin
                        mStb_q  <= 1'b0;
                        mCyc_q  <= 1'b0;
                        state_q <= GAP;
                    end
                end
                GAP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign s_wb_ack_o   = sAck_q;
    assign s_wb_dat_o   = sDat_q;
    assign m_wb_adr_o   = mAdr_q;
    assign m_wb_dat_o   = mDat_q;
    assign m_wb_sel_o   = mSel_q;
    assign m_wb_we_o    = mWe_q;
    assign m_wb_stb_o   = mStb_q;
    assign m_wb_cyc_o   = mCyc_q;
    assign wbuf_empty_o = empty_q;

endmodule

// File: tb/tb_cellram_wbuf.sv
// tb_cellram_wbuf: drives cellram_wbuf from a CPU-side task layer against a behavioural CellRAM controller.
// Read data is predicted from a "latest posted write wins" word memory kept in the bench.
module tb_cellram_wbuf;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic [31:0] s_wb_adr_i, s_wb_dat_i;
    logic [3:0]  s_wb_sel_i;
    logic        s_wb_we_i, s_wb_stb_i, s_wb_cyc_i;
    logic [31:0] s_wb_dat_o;
    logic        s_wb_ack_o;
    logic [31:0] m_wb_adr_o, m_wb_dat_o;
    logic [3:0]  m_wb_sel_o;
    logic        m_wb_we_o, m_wb_stb_o, m_wb_cyc_o;
    logic [31:0] m_wb_dat_i = '0;
    logic        m_wb_ack_i = 1'b0;
    logic        wbuf_empty_o;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
        int          issueEdge;
        int          ackEdge;
        int          gap;
    } xact_t;

    int    assertCnt = 0;
    int    failCnt   = 0;
    int    cycleCnt  = 0;
    int    ctrlLat   = 6;
    bit    ctrlStall = 1'b0;
    int    mCnt      = 0;
    int    lowRun    = 0;
    int    stabErr   = 0;
    xact_t cur;
    xact_t mLog[$];
    logic [31:0] ctrlMem [logic [31:0]];
    logic [31:0] refMem  [logic [31:0]];

    cellram_wbuf #(.DEPTH_LOG2(2), .ADR_WIDTH(32)) dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_i    (wb_rst_i),
        .s_wb_adr_i  (s_wb_adr_i),
        .s_wb_dat_i  (s_wb_dat_i),
        .s_wb_sel_i  (s_wb_sel_i),
        .s_wb_we_i   (s_wb_we_i),
        .s_wb_stb_i  (s_wb_stb_i),
        .s_wb_cyc_i  (s_wb_cyc_i),
        .s_wb_dat_o  (s_wb_dat_o),
        .s_wb_ack_o  (s_wb_ack_o),
        .m_wb_adr_o  (m_wb_adr_o),
        .m_wb_dat_o  (m_wb_dat_o),
        .m_wb_sel_o  (m_wb_sel_o),
        .m_wb_we_o   (m_wb_we_o),
        .m_wb_stb_o  (m_wb_stb_o),
        .m_wb_cyc_o  (m_wb_cyc_o),
        .m_wb_dat_i  (m_wb_dat_i),
        .m_wb_ack_i  (m_wb_ack_i),
        .wbuf_empty_o(wbuf_empty_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    always @(posedge wb_clk_i) cycleCnt <= cycleCnt + 1;

    function automatic logic [31:0] defaultWord(logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] mergeBytes(logic [31:0] old, logic [31:0] nw, logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] memRead(logic [31:0] a);
        return ctrlMem.exists(a) ? ctrlMem[a] : defaultWord(a);
    endfunction

    function automatic logic [31:0] refRead(logic [31:0] a);
        return refMem.exists(a) ? refMem[a] : defaultWord(a);
    endfunction

    // Controller model: acks ctrlLat cycles after stb rises, logs each access and counts stb-low cycles before it.
    always @(negedge wb_clk_i) begin
        if (!m_wb_stb_o) lowRun++;
        if (wb_rst_i) begin
            m_wb_ack_i = 1'b0;
            mCnt       = 0;
        end else if (m_wb_ack_i) begin
            m_wb_ack_i = 1'b0;
            mCnt       = 0;
        end else if (m_wb_stb_o) begin
            if (mCnt == 0) begin
                cur.adr       = m_wb_adr_o;
                cur.dat       = m_wb_dat_o;
                cur.sel       = m_wb_sel_o;
                cur.we        = m_wb_we_o;
                cur.issueEdge = cycleCnt;
                cur.gap       = lowRun;
            end else if ({m_wb_adr_o, m_wb_dat_o, m_wb_sel_o, m_wb_we_o, m_wb_cyc_o} !==
                         {cur.adr, cur.dat, cur.sel, cur.we, 1'b1}) begin
                stabErr++;
            end
            lowRun = 0;
            mCnt++;
            if (!ctrlStall && mCnt >= ctrlLat) begin
                if (cur.we) ctrlMem[cur.adr] = mergeBytes(memRead(cur.adr), cur.dat, cur.sel);
                else        m_wb_dat_i = memRead(cur.adr);
                cur.ackEdge = cycleCnt + 1;
                mLog.push_back(cur);
                m_wb_ack_i = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic cpuWrite(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                            output int lat, output bit ok);
        s_wb_adr_i = adr;
        s_wb_dat_i = dat;
        s_wb_sel_i = sel;
        s_wb_we_i  = 1'b1;
        s_wb_stb_i = 1'b1;
        s_wb_cyc_i = 1'b1;
        ok  = 1'b0;
        lat = 0;
        for (int k = 0; k < 200 && !ok; k++) begin
            tick();
            lat++;
            ok = (s_wb_ack_o === 1'b1);
        end
        s_wb_stb_i = 1'b0;
        s_wb_cyc_i = 1'b0;
        s_wb_we_i  = 1'b0;
        if (ok) refMem[adr] = mergeBytes(refRead(adr), dat, sel);
        tick();
    endtask

    task automatic cpuRead(input logic [31:0] adr, output logic [31:0] dat, output int lat, output bit ok);
        s_wb_adr_i = adr;
        s_wb_sel_i = 4'b1111;
        s_wb_we_i  = 1'b0;
        s_wb_stb_i = 1'b1;
        s_wb_cyc_i = 1'b1;
        ok  = 1'b0;
        lat = 0;
        dat = '0;
        for (int k = 0; k < 200 && !ok; k++) begin
            tick();
            lat++;
            ok = (s_wb_ack_o === 1'b1);
        end
        dat = s_wb_dat_o;
        s_wb_stb_i = 1'b0;
        s_wb_cyc_i = 1'b0;
        tick();
    endtask

    task automatic waitDrain(input int n, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 600 && !ok; k++) begin
            ok = (mLog.size() >= n) && (wbuf_empty_o === 1'b1);
            if (!ok) tick();
        end
    endtask

    task automatic test_reset();
        bit sawStb;
        wb_rst_i   = 1'b1;
        s_wb_adr_i = '0;
        s_wb_dat_i = '0;
        s_wb_sel_i = '0;
        s_wb_we_i  = 1'b0;
        s_wb_stb_i = 1'b0;
        s_wb_cyc_i = 1'b0;
        repeat (3) tick();
        assertCnt++;
        if ({s_wb_ack_o, s_wb_dat_o, m_wb_adr_o, m_wb_dat_o, m_wb_sel_o, m_wb_we_o, m_wb_stb_o, m_wb_cyc_o,
             wbuf_empty_o} !== {1'b0, 32'h0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            failCnt++;
            $display("[TB] FAIL reset_outputs: ack=%0b sdat=%h madr=%h mdat=%h msel=%h we=%0b stb=%0b cyc=%0b empty=%0b, expected all 0 and empty=1",
                     s_wb_ack_o, s_wb_dat_o, m_wb_adr_o, m_wb_dat_o, m_wb_sel_o, m_wb_we_o, m_wb_stb_o, m_wb_cyc_o, wbuf_empty_o);
        end
        wb_rst_i = 1'b0;
        sawStb   = 1'b0;
        repeat (6) begin
            tick();
            if (m_wb_stb_o !== 1'b0) sawStb = 1'b1;
        end
        assertCnt++;
        if (sawStb !== 1'b0) begin
            failCnt++;
            $display("[TB] FAIL idle_stb: stb seen=%0b, expected 0", sawStb);
        end
        assertCnt++;
        if (wbuf_empty_o !== 1'b1) begin
            failCnt++;
            $display("[TB] FAIL idle_empty: got %0b, expected 1", wbuf_empty_o);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        bit ok;
        ctrlLat = 6;
        mLog.delete();
        stabErr = 0;
        for (int i = 0; i < 4; i++) begin
            cpuWrite(32'(4 * i), 32'h1111_1111 * 32'(i + 1), 4'hF, lat, ok);
            assertCnt++;
            if (!ok || lat != 1) begin
                failCnt++;
                $display("[TB] FAIL b2b_ack_lat[%0d]: ok=%0b lat=%0d, expected ok=1 lat=1", i, ok, lat);
            end
            if (i == 0) begin
                assertCnt++;
                if (wbuf_empty_o !== 1'b0) begin
                    failCnt++;
                    $display("[TB] FAIL b2b_not_empty: got %0b, expected 0", wbuf_empty_o);
                end
            end
        end
        waitDrain(4, ok);
        assertCnt++;
        if (!ok || mLog.size() != 4) begin
            failCnt++;
            $display("[TB] FAIL b2b_drain: ok=%0b accesses=%0d, expected 4", ok, mLog.size());
        end
        for (int i = 0; i < 4 && i < mLog.size(); i++) begin
            assertCnt++;
            if ({mLog[i].adr, mLog[i].dat, mLog[i].sel, mLog[i].we} !==
                {32'(4 * i), 32'h1111_1111 * 32'(i + 1), 4'hF, 1'b1}) begin
                failCnt++;
                $display("[TB] FAIL b2b_order[%0d]: adr=%h dat=%h sel=%h we=%0b, expected adr=%h dat=%h sel=f we=1",
                         i, mLog[i].adr, mLog[i].dat, mLog[i].sel, mLog[i].we, 4 * i, 32'h1111_1111 * 32'(i + 1));
            end
            if (i > 0) begin
                // stb drops for GAP and then for the IDLE cycle that picks up the next head entry.
                assertCnt++;
                if (mLog[i].gap != 2) begin
                    failCnt++;
                    $display("[TB] FAIL b2b_gap[%0d]: stb-low cycles=%0d, expected 2", i, mLog[i].gap);
                end
            end
        end
        assertCnt++;
        if (stabErr != 0) begin
            failCnt++;
            $display("[TB] FAIL b2b_stable: changes during access=%0d, expected 0", stabErr);
        end
    endtask

    task automatic test_full_stall();
        int lat, presentEdge;
        bit ok;
        ctrlLat = 12;
        mLog.delete();
        for (int i = 0; i < 4; i++) cpuWrite(32'h40 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'hF, lat, ok);
        presentEdge = cycleCnt;
        cpuWrite(32'h50, 32'h5555_5555, 4'hF, lat, ok);
        assertCnt++;
        if (!ok || mLog.size() < 1) begin
            failCnt++;
            $display("[TB] FAIL full_accept: ok=%0b accesses=%0d, expected ok=1 after first downstream ack", ok, mLog.size());
        end else begin
            assertCnt++;
            if ((presentEdge + lat) < mLog[0].ackEdge || (presentEdge + lat) > mLog[0].ackEdge + 1) begin
                failCnt++;
                $display("[TB] FAIL full_ack_time: ack edge=%0d, expected %0d..%0d", presentEdge + lat,
                         mLog[0].ackEdge, mLog[0].ackEdge + 1);
            end
        end
        waitDrain(5, ok);
        assertCnt++;
        if (!ok || mLog.size() != 5 || mLog[4].adr !== 32'h50 || mLog[4].dat !== 32'h5555_5555) begin
            failCnt++;
            $display("[TB] FAIL full_last: accesses=%0d last adr=%h dat=%h, expected 5 with adr=50 dat=55555555",
                     mLog.size(), mLog[mLog.size()-1].adr, mLog[mLog.size()-1].dat);
        end
    endtask

    task automatic test_read_after_write();
        int lat, presentEdge;
        bit ok;
        logic [31:0] rdat;
        ctrlLat = 6;
        mLog.delete();
        cpuWrite(32'h100, 32'hDEAD_BEEF, 4'hF, lat, ok);
        presentEdge = cycleCnt;
        cpuRead(32'h100, rdat, lat, ok);
        assertCnt++;
        if (!ok || rdat !== 32'hDEAD_BEEF) begin
            failCnt++;
            $display("[TB] FAIL raw_data: ok=%0b got %h, expected deadbeef", ok, rdat);
        end
`ifdef CELLRAM_WBUF_FWD_EN
        assertCnt++;
        if (lat != 1) begin
            failCnt++;
            $display("[TB] FAIL raw_fwd_lat: lat=%0d, expected 1", lat);
        end
        waitDrain(1, ok);
        assertCnt++;
        if (mLog.size() != 1) begin
            failCnt++;
            $display("[TB] FAIL raw_fwd_noread: accesses=%0d, expected 1", mLog.size());
        end
`else
        waitDrain(2, ok);
        assertCnt++;
        if (!ok || mLog.size() != 2 || mLog[1].we !== 1'b0 || mLog[1].adr !== 32'h100) begin
            failCnt++;
            $display("[TB] FAIL raw_read_issued: accesses=%0d, expected write then read of 100", mLog.size());
        end else begin
            assertCnt++;
            if (mLog[1].issueEdge != mLog[0].ackEdge + 2) begin
                failCnt++;
                $display("[TB] FAIL raw_issue_edge: got %0d, expected %0d", mLog[1].issueEdge, mLog[0].ackEdge + 2);
            end
            assertCnt++;
            if (presentEdge + lat != mLog[1].ackEdge) begin
                failCnt++;
                $display("[TB] FAIL raw_ack_edge: got %0d, expected %0d", presentEdge + lat, mLog[1].ackEdge);
            end
        end
`endif
    endtask

`ifdef CELLRAM_WBUF_FWD_EN
    task automatic test_fwd();
        int lat, reads;
        bit ok, sawAck;
        logic [31:0] rdat;
        ctrlStall = 1'b1;
        mLog.delete();
        cpuWrite(32'h200, 32'hCAFE_F00D, 4'hF, lat, ok);
        cpuRead(32'h200, rdat, lat, ok);
        assertCnt++;
        if (!ok || lat != 1 || rdat !== 32'hCAFE_F00D) begin
            failCnt++;
            $display("[TB] FAIL fwd_full: ok=%0b lat=%0d data=%h, expected lat=1 data=cafef00d", ok, lat, rdat);
        end
        cpuWrite(32'h300, 32'h0000_00AB, 4'b0001, lat, ok);
        sawAck = 1'b0;
        fork
            cpuRead(32'h300, rdat, lat, ok);
            begin
                repeat (6) begin
                    tick();
                    if (s_wb_ack_o === 1'b1) sawAck = 1'b1;
                end
                ctrlLat   = 3;
                ctrlStall = 1'b0;
            end
        join
        assertCnt++;
        if (!ok || sawAck || rdat !== refRead(32'h300)) begin
            failCnt++;
            $display("[TB] FAIL fwd_partial: ok=%0b early ack=%0b data=%h, expected drained data=%h",
                     ok, sawAck, rdat, refRead(32'h300));
        end
        waitDrain(3, ok);
        reads = 0;
        foreach (mLog[i]) if (!mLog[i].we) reads++;
        assertCnt++;
        if (!ok || mLog.size() != 3 || reads != 1 || mLog[2].adr !== 32'h300 ||
            mLog[2].issueEdge != mLog[1].ackEdge + 2) begin
            failCnt++;
            $display("[TB] FAIL fwd_drain_order: accesses=%0d reads=%0d, expected 3 accesses with one read of 300 after the drain",
                     mLog.size(), reads);
        end
    endtask
`endif

    task automatic test_random();
        int lat, writes;
        bit ok, drained;
        logic [31:0] adr, dat, rdat, exp;
        logic [3:0]  sel;
        mLog.delete();
        writes = 0;
        for (int n = 0; n < 40; n++) begin
            ctrlLat = $urandom_range(1, 5);
            adr     = 32'h400 + 32'(4 * $urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) begin
                exp = refRead(adr);
                cpuRead(adr, rdat, lat, ok);
                assertCnt++;
                if (!ok || rdat !== exp) begin
                    failCnt++;
                    $display("[TB] FAIL rand_read[%0d] adr=%h: ok=%0b got %h, expected %h", n, adr, ok, rdat, exp);
                end
            end else begin
                sel = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(1, 15));
                dat = $urandom;
                cpuWrite(adr, dat, sel, lat, ok);
                writes++;
                assertCnt++;
                if (!ok) begin
                    failCnt++;
                    $display("[TB] FAIL rand_write[%0d] adr=%h: no ack within bound, expected ack", n, adr);
                end
            end
        end
        waitDrain(0, drained);
        assertCnt++;
        if (!drained || mLog.size() < writes) begin
            failCnt++;
            $display("[TB] FAIL rand_drain: drained=%0b accesses=%0d, expected at least %0d", drained, mLog.size(), writes);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        bit ok, seen, sawStb;
        ctrlLat = 20;
        cpuWrite(32'h600, 32'h1234_5678, 4'hF, lat, ok);
        cpuWrite(32'h604, 32'h8765_4321, 4'hF, lat, ok);
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            seen = (m_wb_stb_o === 1'b1) && (m_wb_we_o === 1'b1);
            if (!seen) tick();
        end
        assertCnt++;
        if (!seen) begin
            failCnt++;
            $display("[TB] FAIL rst_wr_started: stb=%0b we=%0b, expected write in progress", m_wb_stb_o, m_wb_we_o);
        end
        wb_rst_i = 1'b1;
        tick();
        assertCnt++;
        if ({m_wb_stb_o, m_wb_cyc_o, wbuf_empty_o} !== 3'b001) begin
            failCnt++;
            $display("[TB] FAIL rst_mid: stb=%0b cyc=%0b empty=%0b, expected 0 0 1", m_wb_stb_o, m_wb_cyc_o, wbuf_empty_o);
        end
        wb_rst_i = 1'b0;
        sawStb   = 1'b0;
        repeat (12) begin
            tick();
            if (m_wb_stb_o !== 1'b0) sawStb = 1'b1;
        end
        assertCnt++;
        if (sawStb || wbuf_empty_o !== 1'b1) begin
            failCnt++;
            $display("[TB] FAIL rst_discard: stb seen=%0b empty=%0b, expected 0 and 1", sawStb, wbuf_empty_o);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_full_stall();
        test_read_after_write();
`ifdef CELLRAM_WBUF_FWD_EN
        test_fwd();
`endif
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
        $finish;
    end

endmodule
